// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light front end: lane state encoding and
// default timing/width constants.
package traffic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_QUAL    = 2'd1,
      ST_PRESENT = 2'd2,
      ST_RELEASE = 2'd3
   } lane_state_t;

   localparam int DEB_ON_DEF  = 4;
   localparam int DEB_OFF_DEF = 4;
   localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/sensor_conditioner_if.sv
// Bundle of raw sensor inputs and conditioned outputs for both roads.
interface sensor_conditioner_if #(
   parameter int CNT_W = traffic_pkg::CNT_W_DEF
);
   logic             sa_raw;
   logic             sb_raw;
   logic             cnt_clr;
   logic             sa_det;
   logic             sb_det;
   logic             sa_arrive;
   logic             sb_arrive;
   logic [CNT_W-1:0] sa_count;
   logic [CNT_W-1:0] sb_count;

   modport master (
      output sa_raw, sb_raw, cnt_clr,
      input  sa_det, sb_det, sa_arrive, sb_arrive, sa_count, sb_count
   );

   modport slave (
      input  sa_raw, sb_raw, cnt_clr,
      output sa_det, sb_det, sa_arrive, sb_arrive, sa_count, sb_count
   );
endinterface

// File: rtl/sensor_lane.sv
// One road: two-flop synchroniser, asymmetric debounce FSM, arrival pulse and
// saturating arrival counter.
//
// state   | meaning
// IDLE    | no vehicle, det=0
// QUAL    | input high, counting toward DEB_ON, det=0
// PRESENT | vehicle present, det=1
// RELEASE | input low, counting toward DEB_OFF, det=1
module sensor_lane
   import traffic_pkg::*;
#(
   parameter int DEB_ON  = DEB_ON_DEF,
   parameter int DEB_OFF = DEB_OFF_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_raw,
   input  logic             i_cnt_clr,
   output logic             o_det,
   output logic             o_arrive,
   output logic [CNT_W-1:0] o_count
);

   localparam logic [7:0]       ON_LAST  = 8'(DEB_ON - 1);
   localparam logic [7:0]       OFF_LAST = 8'(DEB_OFF - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic             r_s1;
   logic             r_s2;
   lane_state_t      r_state;
   logic [7:0]       r_dcnt;
   logic             r_det;
   logic             r_arrive;
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1     <= 1'b0;
         r_s2     <= 1'b0;
         r_state  <= ST_IDLE;
         r_dcnt   <= 8'd0;
         r_det    <= 1'b0;
         r_arrive <= 1'b0;
      end else begin
         r_s1     <= i_raw;
         r_s2     <= r_s1;
         r_arrive <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_s2) begin
                  if (DEB_ON == 1) begin
                     r_state  <= ST_PRESENT;
                     r_det    <= 1'b1;
                     r_arrive <= 1'b1;
                     r_dcnt   <= 8'd0;
                  end else begin
                     r_state <= ST_QUAL;
                     r_dcnt  <= 8'd1;
                  end
               end
            end
            ST_QUAL: begin
               if (!r_s2) begin
                  r_state <= ST_IDLE;
                  r_dcnt  <= 8'd0;
               end else if (r_dcnt == ON_LAST) begin
                  r_state  <= ST_PRESENT;
                  r_det    <= 1'b1;
                  r_arrive <= 1'b1;
                  r_dcnt   <= 8'd0;
               end else begin
                  r_dcnt <= r_dcnt + 8'd1;
               end
            end
            ST_PRESENT: begin
               if (!r_s2) begin
                  if (DEB_OFF == 1) begin
                     r_state <= ST_IDLE;
                     r_det   <= 1'b0;
                     r_dcnt  <= 8'd0;
                  end else begin
                     r_state <= ST_RELEASE;
                     r_dcnt  <= 8'd1;
                  end
               end
            end
            ST_RELEASE: begin
               // A dropout that recovers in time is not a new arrival.
               if (r_s2) begin
                  r_state <= ST_PRESENT;
                  r_dcnt  <= 8'd0;
               end else if (r_dcnt == OFF_LAST) begin
                  r_state <= ST_IDLE;
                  r_det   <= 1'b0;
                  r_dcnt  <= 8'd0;
               end else begin
                  r_dcnt <= r_dcnt + 8'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_det   <= 1'b0;
               r_dcnt  <= 8'd0;
            end
         endcase
      end
   end

   // Clear wins over a coincident arrival.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_cnt_clr) begin
         r_count <= '0;
      end else if (r_arrive && (r_count != CNT_MAX)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_det    = r_det;
   assign o_arrive = r_arrive;
   assign o_count  = r_count;

endmodule

// File: rtl/sensor_conditioner.sv
// Vehicle-loop front end: two independent sensor lanes sharing the counter
// clear, feeding the traffic controller's Sa/Sb inputs.
module sensor_conditioner
   import traffic_pkg::*;
#(
   parameter int DEB_ON  = DEB_ON_DEF,
   parameter int DEB_OFF = DEB_OFF_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   sensor_conditioner_if.slave  io_bus
);

   sensor_lane #(
      .DEB_ON  (DEB_ON),
      .DEB_OFF (DEB_OFF),
      .CNT_W   (CNT_W)
   ) u_lane_a (
      .clk       (clk),
      .reset     (reset),
      .i_raw     (io_bus.sa_raw),
      .i_cnt_clr (io_bus.cnt_clr),
      .o_det     (io_bus.sa_det),
      .o_arrive  (io_bus.sa_arrive),
      .o_count   (io_bus.sa_count)
   );

   sensor_lane #(
      .DEB_ON  (DEB_ON),
      .DEB_OFF (DEB_OFF),
      .CNT_W   (CNT_W)
   ) u_lane_b (
      .clk       (clk),
      .reset     (reset),
      .i_raw     (io_bus.sb_raw),
      .i_cnt_clr (io_bus.cnt_clr),
      .o_det     (io_bus.sb_det),
      .o_arrive  (io_bus.sb_arrive),
      .o_count   (io_bus.sb_count)
   );

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner: vector table plus hand-written
// saturation, clear-priority and async-reset sequences.
module tb_sensor_conditioner;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;
   int   acc_sa_arr;
   int   acc_sb_arr;

   sensor_conditioner_if #(.CNT_W(8)) bus ();

   sensor_conditioner #(
      .DEB_ON  (4),
      .DEB_OFF (4),
      .CNT_W   (8)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .io_bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string name;
      logic  sa;
      logic  sb;
      logic  clr;
      int    cyc;
      int    e_sa_det;
      int    e_sb_det;
      int    e_sa_arr;
      int    e_sb_arr;
      int    e_sa_cnt;
      int    e_sb_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(string nm, logic sa, logic sb, logic clr, int cyc,
                               int sad, int sbd, int saa, int sba, int sac, int sbc);
      vec_t v;
      v.name = nm; v.sa = sa; v.sb = sb; v.clr = clr; v.cyc = cyc;
      v.e_sa_det = sad; v.e_sb_det = sbd; v.e_sa_arr = saa; v.e_sb_arr = sba;
      v.e_sa_cnt = sac; v.e_sb_cnt = sbc;
      vecs.push_back(v);
   endfunction

   task automatic chk(string nm, int act, int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      acc_sa_arr += int'(bus.sa_arrive);
      acc_sb_arr += int'(bus.sb_arrive);
   endtask

   task automatic steps(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      acc_sa_arr = 0;
      acc_sb_arr = 0;
      bus.sa_raw  = 1'b0;
      bus.sb_raw  = 1'b0;
      bus.cnt_clr = 1'b0;
      reset = 1'b1;

      //   name            sa sb clr cyc  saD sbD saA sbA saC sbC
      add("idle",          0, 0, 0, 20,   0,  0,  0,  0,  0,  0);
      add("sb_qual",       0, 1, 0,  5,   0,  0,  0,  0,  0,  0);
      add("sb_det",        0, 1, 0,  1,   0,  1,  0,  1,  0,  0);
      add("sb_cnt",        0, 1, 0,  1,   0,  1,  0,  0,  0,  1);
      add("sb_hold",       0, 1, 0, 10,   0,  1,  0,  0,  0,  1);
      add("sb_rel",        0, 0, 0,  6,   0,  0,  0,  0,  0,  1);
      add("sa_glitch3",    1, 0, 0,  3,   0,  0,  0,  0,  0,  1);
      add("sa_gl_low",     0, 0, 0,  8,   0,  0,  0,  0,  0,  1);
      add("sa_p4",         1, 0, 0,  4,   0,  0,  0,  0,  0,  1);
      add("sa_p4_low2",    0, 0, 0,  2,   1,  0,  1,  0,  0,  1);
      add("sa_p4_hold",    0, 0, 0,  3,   1,  0,  0,  0,  1,  1);
      add("sa_p4_drop",    0, 0, 0,  1,   0,  0,  0,  0,  1,  1);
      add("sa_arr2",       1, 0, 0,  7,   1,  0,  1,  0,  2,  1);
      add("sa_dip2",       0, 0, 0,  2,   1,  0,  0,  0,  2,  1);
      add("sa_dip2_back",  1, 0, 0, 10,   1,  0,  0,  0,  2,  1);
      add("sa_dip3",       0, 0, 0,  3,   1,  0,  0,  0,  2,  1);
      add("sa_dip3_back",  1, 0, 0, 10,   1,  0,  0,  0,  2,  1);
      add("sa_rel5",       0, 0, 0,  5,   1,  0,  0,  0,  2,  1);
      add("sa_rel1",       0, 0, 0,  1,   0,  0,  0,  0,  2,  1);
      add("both",          1, 1, 0,  7,   1,  1,  1,  1,  3,  2);
      add("both_rel",      0, 0, 0,  6,   0,  0,  0,  0,  3,  2);
      add("clr",           0, 0, 1,  1,   0,  0,  0,  0,  0,  0);
      add("post_clr",      0, 0, 0,  2,   0,  0,  0,  0,  0,  0);

      steps(3);
      chk("rst_sa_det", int'(bus.sa_det), 0);
      chk("rst_sb_det", int'(bus.sb_det), 0);
      chk("rst_sa_arrive", int'(bus.sa_arrive), 0);
      chk("rst_sa_count", int'(bus.sa_count), 0);
      chk("rst_sb_count", int'(bus.sb_count), 0);
      reset = 1'b0;

      foreach (vecs[k]) begin
         bus.sa_raw  = vecs[k].sa;
         bus.sb_raw  = vecs[k].sb;
         bus.cnt_clr = vecs[k].clr;
         acc_sa_arr = 0;
         acc_sb_arr = 0;
         steps(vecs[k].cyc);
         chk({vecs[k].name, ".sa_det"}, int'(bus.sa_det), vecs[k].e_sa_det);
         chk({vecs[k].name, ".sb_det"}, int'(bus.sb_det), vecs[k].e_sb_det);
         chk({vecs[k].name, ".sa_arr"}, acc_sa_arr, vecs[k].e_sa_arr);
         chk({vecs[k].name, ".sb_arr"}, acc_sb_arr, vecs[k].e_sb_arr);
         chk({vecs[k].name, ".sa_cnt"}, int'(bus.sa_count), vecs[k].e_sa_cnt);
         chk({vecs[k].name, ".sb_cnt"}, int'(bus.sb_count), vecs[k].e_sb_cnt);
      end
      bus.cnt_clr = 1'b0;

      // Saturation: 255 clean arrivals, then one more.
      for (int i = 0; i < 255; i++) begin
         bus.sa_raw = 1'b1; steps(7);
         bus.sa_raw = 1'b0; steps(6);
      end
      chk("sat_255", int'(bus.sa_count), 255);
      bus.sa_raw = 1'b1; steps(7);
      bus.sa_raw = 1'b0; steps(6);
      chk("sat_256", int'(bus.sa_count), 255);
      chk("sat_det_low", int'(bus.sa_det), 0);

      // Clear coinciding with an arrival pulse.
      bus.sa_raw = 1'b1;
      steps(6);
      chk("clr_arr_pulse", int'(bus.sa_arrive), 1);
      bus.cnt_clr = 1'b1;
      step();
      bus.cnt_clr = 1'b0;
      chk("clr_arr_cnt", int'(bus.sa_count), 0);
      step();
      chk("clr_arr_cnt_after", int'(bus.sa_count), 0);
      bus.sa_raw = 1'b0;
      steps(6);
      chk("clr_arr_rel", int'(bus.sa_det), 0);

      // Async reset in the middle of road A qualification, road B present.
      bus.sb_raw = 1'b1;
      steps(7);
      chk("pre_rst_sb_det", int'(bus.sb_det), 1);
      chk("pre_rst_sb_cnt", int'(bus.sb_count), 1);
      bus.sa_raw = 1'b1;
      steps(3);
      #2;
      reset = 1'b1;
      #1;
      chk("async_sb_det", int'(bus.sb_det), 0);
      chk("async_sb_cnt", int'(bus.sb_count), 0);
      chk("async_sa_det", int'(bus.sa_det), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      acc_sa_arr = 0;
      acc_sb_arr = 0;
      steps(5);
      chk("rerun_sa_det_early", int'(bus.sa_det), 0);
      chk("rerun_sa_arr_early", acc_sa_arr, 0);
      chk("rerun_sb_arr_early", acc_sb_arr, 0);
      step();
      chk("rerun_sa_det", int'(bus.sa_det), 1);
      chk("rerun_sa_arrive", int'(bus.sa_arrive), 1);
      chk("rerun_sb_det", int'(bus.sb_det), 1);
      step();
      chk("rerun_sa_arrive_off", int'(bus.sa_arrive), 0);
      chk("rerun_sa_cnt", int'(bus.sa_count), 1);
      chk("rerun_sb_cnt", int'(bus.sb_count), 1);
      steps(5);
      chk("rerun_sa_arr_total", acc_sa_arr, 1);
      chk("rerun_sb_arr_total", acc_sb_arr, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sensor_conditioner.md
Name: sensor_conditioner

Overview:
- Upstream front end for the two-road traffic light controller.
- Takes the raw, asynchronous vehicle-loop sensor inputs for road A and road B.
- Per road: synchronises, debounces with asymmetric qualify/release timing, emits arrival pulses and keeps saturating vehicle counts.
- Its clean sa_det/sb_det outputs drive the controller's Sa/Sb inputs directly.

Parameters:
- DEB_ON, 4, consecutive synchronised-high cycles required to assert detection (1..255).
- DEB_OFF, 4, consecutive synchronised-low cycles required to drop detection (1..255).
- CNT_W, 8, width of each per-road vehicle counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- sa_raw  in  1  road A loop sensor, asynchronous, may bounce.
- sb_raw  in  1  road B loop sensor, asynchronous, may bounce.
- cnt_clr  in  1  synchronous clear of both vehicle counters.
- sa_det  out  1  debounced road A presence; feeds controller Sa.
- sb_det  out  1  debounced road B presence; feeds controller Sb.
- sa_arrive  out  1  one-cycle pulse on sa_det rising.
- sb_arrive  out  1  one-cycle pulse on sb_det rising.
- sa_count  out  CNT_W  road A arrivals, saturating.
- sb_count  out  CNT_W  road B arrivals, saturating.

Behaviour:
- Reset (async assert, sync-to-clk deassert by the top level): sync flops 0, states IDLE, debounce counters 0, all outputs 0.
- Each road is independent and identical. Road B is the same as road A with sb_* signals.
- Synchroniser: two flops, s1 <= raw; s2 <= s1. Only s2 is used downstream.
- FSM per road, 8-bit debounce counter dcnt:
  - IDLE (det=0): s2=1 -> QUAL, dcnt=1; else stay.
  - QUAL (det=0): s2=0 -> IDLE, dcnt=0 (glitch rejected). s2=1 and dcnt==DEB_ON-1 -> PRESENT. Else dcnt++.
  - PRESENT (det=1): s2=0 -> RELEASE, dcnt=1; else stay.
  - RELEASE (det=1): s2=1 -> PRESENT, dcnt=0 (dropout rejected). s2=0 and dcnt==DEB_OFF-1 -> IDLE. Else dcnt++.
- DEB_ON=1 special case: IDLE with s2=1 goes straight to PRESENT. DEB_OFF=1 is handled symmetrically.
- det is a registered output, high in PRESENT and RELEASE.
- Latency: raw rising and held, first sampled at edge n -> det high after edge n+1+DEB_ON. Release timing is symmetric with DEB_OFF.
- arrive: registered, high for exactly the first cycle det is high (transition into PRESENT from QUAL/IDLE). It does not fire on RELEASE->PRESENT.
- Counter:
  - Increments by 1 on the cycle arrive is high.
  - Saturates at 2^CNT_W-1 with no wrap.
  - cnt_clr has priority: if arrive and cnt_clr coincide, count becomes 0 and that arrival is not counted.
- Reset mid-qualification or mid-release aborts immediately to IDLE. No pulse is generated on reset release.
- Both roads detecting in the same cycle is legal and fully independent; conflict resolution belongs to the controller.

Decomposition:
- Shared package traffic_pkg:
  - 2-bit state encoding IDLE=0, QUAL=1, PRESENT=2, RELEASE=3.
  - Default constants DEB_ON_DEF=4, DEB_OFF_DEF=4, CNT_W_DEF=8.
- Sub-module sensor_lane: synchroniser, FSM, dcnt, det/arrive/count for one road. Instantiated twice.
- The top level only wires the two lanes and fans cnt_clr out to both.

Test Plan (defaults, 10 ns clock):
- Reset then sa_raw=sb_raw=0 for 20 cycles -> all outputs 0, counts 0.
- sb_raw high at edge 10 and held -> sb_det rises after edge 15, sb_arrive high for 1 cycle at edge 15, sb_count=1; sa_det stays 0.
- sa_raw pulse of 3 cycles (shorter than DEB_ON) -> sa_det never asserts, sa_count stays 0. A 4-cycle pulse -> sa_det asserts and holds 4 cycles after the sync'd low.
- sa_det high, then sa_raw low for 2 cycles, then high -> no sa_det drop, no second arrive, sa_count unchanged.
- 255 clean arrivals on road A, then one more -> sa_count=255 both times. cnt_clr on the same cycle as an arrive -> sa_count=0.
- Async reset asserted mid-QUAL (between clock edges) -> outputs 0 immediately. After release with sa_raw held high -> full DEB_ON qualification again, single arrive, count=1.
